// File: rtl/cursor_pkg.sv
// Shared types and defaults for the cursor sampler slice.
package cursor_pkg;

   localparam int unsigned COORD_W      = 10;
   localparam int unsigned DEF_SCREEN_W = 640;
   localparam int unsigned DEF_SCREEN_H = 480;

   typedef logic [COORD_W-1:0] coord_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_FILTER,
      ST_PUBLISH
   } state_t;

endpackage

// File: rtl/cursor_sampler_if.sv
// Frame/mouse inputs and published cursor outputs of the cursor sampler.
interface cursor_sampler_if;
   import cursor_pkg::*;

   logic   frame_vs;
   coord_t mouse_x;
   coord_t mouse_y;
   coord_t cursor_x;
   coord_t cursor_y;
   logic   cursor_valid;
   logic   cursor_moved;
   logic   frame_tick;

   modport master (
      output frame_vs, mouse_x, mouse_y,
      input  cursor_x, cursor_y, cursor_valid, cursor_moved, frame_tick
   );

   modport slave (
      input  frame_vs, mouse_x, mouse_y,
      output cursor_x, cursor_y, cursor_valid, cursor_moved, frame_tick
   );

endinterface

// File: rtl/cursor_axis_filter.sv
// One cursor axis: clamp on capture, boxcar average over 2^AVG_LOG2 frames, publish.
module cursor_axis_filter
   import cursor_pkg::*;
#(
   parameter int unsigned LIMIT    = DEF_SCREEN_W - 1,
   parameter int unsigned AVG_LOG2 = 2
) (
   input  logic   Clk,
   input  logic   Reset,
   input  logic   capture_en,
   input  logic   filter_en,
   input  logic   publish_en,
   input  logic   preload,
   input  coord_t raw,
   output coord_t value,
   output logic   differs_c
);

   localparam int unsigned DEPTH   = 1 << AVG_LOG2;
   localparam int unsigned SUM_W   = COORD_W + AVG_LOG2;
   localparam coord_t      LIMIT_C = COORD_W'(LIMIT);

   coord_t           sample;
   coord_t           hist [DEPTH];
   logic [SUM_W-1:0] sum;
   coord_t           avg_c;

   assign avg_c     = COORD_W'(sum >> AVG_LOG2);
   assign differs_c = (avg_c != value);

   // sum always equals the total of hist, so it cannot exceed DEPTH*LIMIT
   always_ff @(posedge Clk) begin
      if (Reset) begin
         sample <= '0;
         sum    <= '0;
         value  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) hist[i] <= '0;
      end else begin
         if (capture_en) sample <= (raw > LIMIT_C) ? LIMIT_C : raw;
         if (filter_en) begin
            if (preload) begin
               for (int unsigned i = 0; i < DEPTH; i++) hist[i] <= sample;
               sum <= SUM_W'(sample) << AVG_LOG2;
            end else begin
               hist[0] <= sample;
               for (int unsigned i = 1; i < DEPTH; i++) hist[i] <= hist[i-1];
               sum <= sum + SUM_W'(sample) - SUM_W'(hist[DEPTH-1]);
            end
         end
         if (publish_en) value <= avg_c;
      end
   end

endmodule

// File: rtl/cursor_sampler.sv
// Samples the mouse position once per VGA frame, filters it and publishes it.
module cursor_sampler
   import cursor_pkg::*;
#(
   parameter int unsigned SCREEN_W = DEF_SCREEN_W,
   parameter int unsigned SCREEN_H = DEF_SCREEN_H,
   parameter int unsigned AVG_LOG2 = 2
) (
   input  logic          Clk,
   input  logic          Reset,
   cursor_sampler_if.slave bus
);

   state_t state;
   logic   sync1, sync2, sync3;
   logic   tick_c;
   logic   first;
   logic   frame_tick;
   logic   cursor_valid;
   logic   cursor_moved;
   logic   capture_c, filter_c, publish_c;
   coord_t x_val, y_val;
   logic   x_diff_c, y_diff_c;

   assign tick_c    = sync2 & ~sync3;
   assign capture_c = (state == ST_CAPTURE);
   assign filter_c  = (state == ST_FILTER);
   assign publish_c = (state == ST_PUBLISH);

   // Sequencer: cursor_valid lands the cycle after PUBLISH, 3 cycles after frame_tick
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state        <= ST_IDLE;
         sync1        <= 1'b0;
         sync2        <= 1'b0;
         sync3        <= 1'b0;
         frame_tick   <= 1'b0;
         cursor_valid <= 1'b0;
         cursor_moved <= 1'b0;
         first        <= 1'b1;
      end else begin
         sync1        <= bus.frame_vs;
         sync2        <= sync1;
         sync3        <= sync2;
         frame_tick   <= tick_c;
         cursor_valid <= 1'b0;
         cursor_moved <= 1'b0;
         case (state)
            ST_IDLE:    if (tick_c) state <= ST_CAPTURE;
            ST_CAPTURE: state <= ST_FILTER;
            ST_FILTER:  state <= ST_PUBLISH;
            ST_PUBLISH: begin
               state        <= ST_IDLE;
               cursor_valid <= 1'b1;
               cursor_moved <= ~first & (x_diff_c | y_diff_c);
               first        <= 1'b0;
            end
            default:    state <= ST_IDLE;
         endcase
      end
   end

   cursor_axis_filter #(
      .LIMIT    (SCREEN_W - 1),
      .AVG_LOG2 (AVG_LOG2)
   ) u_axis_x (
      .Clk        (Clk),
      .Reset      (Reset),
      .capture_en (capture_c),
      .filter_en  (filter_c),
      .publish_en (publish_c),
      .preload    (first),
      .raw        (bus.mouse_x),
      .value      (x_val),
      .differs_c  (x_diff_c)
   );

   cursor_axis_filter #(
      .LIMIT    (SCREEN_H - 1),
      .AVG_LOG2 (AVG_LOG2)
   ) u_axis_y (
      .Clk        (Clk),
      .Reset      (Reset),
      .capture_en (capture_c),
      .filter_en  (filter_c),
      .publish_en (publish_c),
      .preload    (first),
      .raw        (bus.mouse_y),
      .value      (y_val),
      .differs_c  (y_diff_c)
   );

   assign bus.cursor_x     = x_val;
   assign bus.cursor_y     = y_val;
   assign bus.cursor_valid = cursor_valid;
   assign bus.cursor_moved = cursor_moved;
   assign bus.frame_tick   = frame_tick;

endmodule

// File: tb/tb_cursor_sampler.sv
// Scoreboard bench for cursor_sampler: frame-level reference model plus per-cycle monitor.
module tb_cursor_sampler;
   import cursor_pkg::*;

   localparam int SW   = 640;
   localparam int SH   = 480;
   localparam int AVG  = 2;
   localparam int NAVG = 1 << AVG;

   typedef struct {
      int cyc;
      int x;
      int y;
      bit moved;
   } pub_t;

   logic   Clk = 1'b0;
   logic   Reset;
   coord_t mx, my;
   bit     toggle_en;
   bit     drain_req;
   bit     drain_done;

   int   n_cmp;
   int   n_bad;
   int   cyc;
   bit   started;
   bit   prev_vs;
   bit   first_m;
   int   last_x, last_y;
   int   disp_x, disp_y;
   int   busy_until;
   int   hx[$], hy[$];
   int   tickq[$];
   pub_t pubq[$];

   cursor_sampler_if bus ();

   cursor_sampler #(
      .SCREEN_W (SW),
      .SCREEN_H (SH),
      .AVG_LOG2 (AVG)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus.slave)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   // Reference: clamp, keep the last NAVG samples, publish their truncated mean
   function automatic void model_capture(input int rx, input int ry);
      int   cx, cy, sx, sy;
      pub_t p;
      cx = (rx > SW - 1) ? SW - 1 : rx;
      cy = (ry > SH - 1) ? SH - 1 : ry;
      if (first_m) begin
         hx.delete();
         hy.delete();
         repeat (NAVG) begin
            hx.push_back(cx);
            hy.push_back(cy);
         end
      end else begin
         hx.push_back(cx);
         hy.push_back(cy);
         void'(hx.pop_front());
         void'(hy.pop_front());
      end
      sx = 0;
      sy = 0;
      foreach (hx[i]) sx += hx[i];
      foreach (hy[i]) sy += hy[i];
      p.cyc   = cyc + 3;
      p.x     = sx / NAVG;
      p.y     = sy / NAVG;
      p.moved = !first_m && (p.x != last_x || p.y != last_y);
      first_m = 1'b0;
      last_x  = p.x;
      last_y  = p.y;
      pubq.push_back(p);
   endfunction

   // Model update at each rising edge, comparisons at the following falling edge
   always begin
      bit   exp_tick;
      pub_t p;
      @(posedge Clk);
      cyc++;
      if (Reset) begin
         started    = 1'b1;
         prev_vs    = 1'b0;
         first_m    = 1'b1;
         last_x     = 0;
         last_y     = 0;
         disp_x     = 0;
         disp_y     = 0;
         busy_until = 0;
         hx.delete();
         hy.delete();
         tickq.delete();
         pubq.delete();
      end else begin
         if (bus.frame_vs && !prev_vs) tickq.push_back(cyc + 2);
         prev_vs = bus.frame_vs;
      end
      @(negedge Clk);
      if (started) begin
         exp_tick = (tickq.size() > 0) && (tickq[0] == cyc);
         if (exp_tick) void'(tickq.pop_front());
         chk("frame_tick", int'(bus.frame_tick), int'(exp_tick));
         if (exp_tick && cyc >= busy_until) begin
            busy_until = cyc + 4;
            model_capture(int'(bus.mouse_x), int'(bus.mouse_y));
         end
         if (pubq.size() > 0 && pubq[0].cyc == cyc) begin
            p = pubq.pop_front();
            chk("cursor_valid", int'(bus.cursor_valid), 1);
            chk("cursor_x", int'(bus.cursor_x), p.x);
            chk("cursor_y", int'(bus.cursor_y), p.y);
            chk("cursor_moved", int'(bus.cursor_moved), int'(p.moved));
            disp_x = p.x;
            disp_y = p.y;
         end else begin
            chk("cursor_valid", int'(bus.cursor_valid), 0);
            chk("cursor_moved_idle", int'(bus.cursor_moved), 0);
            chk("hold_x", int'(bus.cursor_x), disp_x);
            chk("hold_y", int'(bus.cursor_y), disp_y);
         end
         if (drain_req && !drain_done) begin
            chk("drain_pub", pubq.size(), 0);
            chk("drain_tick", tickq.size(), 0);
            drain_done = 1'b1;
         end
      end
   end

   // Mouse driver; in toggle mode x gets a fresh random value every cycle
   always begin
      @(posedge Clk);
      #2;
      bus.mouse_x = toggle_en ? COORD_W'($urandom) : mx;
      bus.mouse_y = my;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic frame(input int hold);
      bus.frame_vs = 1'b1;
      step(hold);
      bus.frame_vs = 1'b0;
      step(8);
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      step(2);
      Reset = 1'b0;
      step(2);
   endtask

   initial begin
      Reset        = 1'b1;
      bus.frame_vs = 1'b0;
      mx           = '0;
      my           = '0;
      toggle_en    = 1'b0;
      drain_req    = 1'b0;
      step(3);
      Reset = 1'b0;
      step(3);

      // first publish after reset: preloaded, no movement flag
      mx = 10'd100; my = 10'd200;
      frame(2);

      // glide from a (0,0) prime toward x=400
      do_reset();
      mx = 10'd0; my = 10'd0;
      frame(2);
      mx = 10'd400;
      repeat (4) frame(2);

      // clamping at the screen edge, then an equivalent in-range position
      mx = 10'd1023; my = 10'd1000;
      repeat (5) frame(2);
      mx = 10'd639; my = 10'd479;
      frame(2);

      // long vsync pulse, then a second edge landing mid-sequence
      mx = 10'd300; my = 10'd100;
      frame(1000);
      bus.frame_vs = 1'b1;
      step(1);
      bus.frame_vs = 1'b0;
      step(1);
      bus.frame_vs = 1'b1;
      step(2);
      bus.frame_vs = 1'b0;
      step(8);

      // reset during FILTER aborts the publish; next frame preloads
      mx = 10'd700; my = 10'd20;
      bus.frame_vs = 1'b1;
      step(2);
      bus.frame_vs = 1'b0;
      step(2);
      Reset = 1'b1;
      step(1);
      Reset = 1'b0;
      step(4);
      mx = 10'd50; my = 10'd60;
      frame(2);

      // x changes every cycle: only the captured value may matter
      toggle_en = 1'b1;
      repeat (6) frame(3);
      toggle_en = 1'b0;

      // random positions, pulse widths and gaps, occasional reset
      repeat (60) begin
         mx = COORD_W'($urandom_range(0, 1023));
         my = COORD_W'($urandom_range(0, 1023));
         bus.frame_vs = 1'b1;
         step($urandom_range(1, 4));
         bus.frame_vs = 1'b0;
         step($urandom_range(1, 8));
         if ($urandom_range(0, 14) == 0) do_reset();
      end

      step(20);
      drain_req = 1'b1;
      step(3);
      if (!drain_done) $display("FAIL drain_monitor: got 0, expected 1");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, drain_done ? n_bad : n_bad + 1);
      $finish;
   end

endmodule

// File: doc/cursor_sampler.md
CURSOR_SAMPLER -- requirements
Module: cursor_sampler

Interface
REQ-001 Parameter SCREEN_W, default 640: visible width in pixels; X clamp limit is SCREEN_W-1.
REQ-002 Parameter SCREEN_H, default 480: visible height in pixels; Y clamp limit is SCREEN_H-1.
REQ-003 Parameter AVG_LOG2, default 2, legal range 0..3: the filter averages 2^AVG_LOG2 frame samples.
REQ-004 Clk  input  1: the single clock, CLOCK_50 domain; all state updates on its rising edge.
REQ-005 Reset  input  1: synchronous, active-high reset.
REQ-006 frame_vs  input  1: VGA vertical sync, asynchronous to Clk.
REQ-007 mouse_x  input  10: raw cursor X from the USB/NIOS export, may change at any cycle.
REQ-008 mouse_y  input  10: raw cursor Y from the USB/NIOS export, may change at any cycle.
REQ-009 cursor_x  output  10: filtered, clamped X, stable between publishes.
REQ-010 cursor_y  output  10: filtered, clamped Y, stable between publishes.
REQ-011 cursor_valid  output  1: one-cycle pulse when cursor_x/cursor_y update.
REQ-012 cursor_moved  output  1: one-cycle pulse, coincident with cursor_valid, when either published coordinate differs from its previous value.
REQ-013 frame_tick  output  1: one-cycle pulse on each detected frame_vs rising edge.

Function
REQ-014 frame_vs SHALL pass through a 2-flop synchronizer plus a third history flop; frame_tick = sync2 & ~sync3.
REQ-015 The FSM SHALL have states IDLE, CAPTURE, FILTER, PUBLISH, with transitions IDLE->CAPTURE on frame_tick, then CAPTURE->FILTER->PUBLISH->IDLE unconditionally.
REQ-016 In CAPTURE the block SHALL register min(mouse_x, SCREEN_W-1) and min(mouse_y, SCREEN_H-1).
REQ-017 In FILTER, per axis, the captured sample SHALL shift into a 2^AVG_LOG2-deep history, and the running sum SHALL be updated as sum + new - oldest.
REQ-018 The sum SHALL be 10+AVG_LOG2 bits wide and SHALL never overflow.
REQ-019 In PUBLISH the block SHALL drive cursor_x/y = sum >> AVG_LOG2 (truncating) and SHALL assert cursor_valid for exactly that cycle; it SHALL assert cursor_moved in the same cycle if the new value differs from the old.
REQ-020 Latency from the frame_tick cycle to the cursor_valid cycle SHALL be exactly 3 Clk cycles.
REQ-021 The first capture after reset SHALL preload every history tap and the sum with that sample, so there is no glide from 0; this first publish SHALL NOT assert cursor_moved.
REQ-022 A frame_tick arriving while the FSM is not in IDLE SHALL be ignored; frame_tick itself SHALL still pulse.
REQ-023 A frame_vs pulse held high for many cycles SHALL produce exactly one frame_tick.
REQ-024 With AVG_LOG2=0, the output SHALL equal the clamped captured sample, with the same 3-cycle latency.
REQ-025 Changes on mouse_x/y outside the CAPTURE cycle SHALL have no effect.

Reset
REQ-026 While Reset=1, the FSM SHALL go to IDLE, synchronizer flops to 0, history, sums and cursor_x/y to 0, cursor_valid/cursor_moved/frame_tick to 0, and the first-sample flag to set.
REQ-027 Reset asserted mid-sequence (CAPTURE/FILTER/PUBLISH) SHALL abort it with no cursor_valid pulse.
REQ-028 After Reset is released, the next publish SHALL behave as the first-sample case.

Structure
REQ-029 A shared package cursor_pkg SHALL hold the FSM state enum, the default SCREEN_W/SCREEN_H constants and the 10-bit coordinate typedef.
REQ-030 Per-axis filtering SHALL be one sub-module, cursor_axis_filter (clamp limit, AVG_LOG2 parameters), instantiated twice.
REQ-031 The synchronizer and FSM SHALL live in cursor_sampler.

Verification
REQ-032 Reset, then mouse=(100,200), raise frame_vs -> frame_tick 3 cycles after the edge (2 sync + 1), cursor_valid 3 cycles later, cursor=(100,200), cursor_moved=0.
REQ-033 AVG_LOG2=2, primed at (0,0) by a first capture at (0,0), then four frames at x=400 -> cursor_x = 100, 200, 300, 400 on successive publishes, cursor_moved=1 each time.
REQ-034 mouse=(1023,1000) -> cursor=(639,479) after priming; mouse=(639,479) -> unchanged, cursor_moved=0.
REQ-035 frame_vs held high 1000 cycles -> exactly one frame_tick and one cursor_valid; a second synthetic tick forced during FILTER -> ignored.
REQ-036 Reset asserted in the FILTER cycle -> no cursor_valid, outputs 0; next frame at (50,60) -> cursor=(50,60) immediately (preload), cursor_moved=0.
REQ-037 mouse_x toggles every cycle except during CAPTURE -> the published value equals the value sampled in CAPTURE.
